// File: rtl/pipeline_issue_ctrl.sv
// In-order instruction issue controller: a small FIFO instruction queue feeding a
// registered issue stage, with a two-deep write scoreboard for RAW hazard stalls.
module pipeline_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  in_ra1,
    input  logic [3:0]  in_ra2,
    input  logic [3:0]  in_rwa,
    input  logic [3:0]  in_func,
    input  logic [7:0]  in_ma,
    output logic        in_ready,
    input  logic        hold,
    input  logic        flush,
    output logic        iss_valid,
    output logic [3:0]  iss_ra1,
    output logic [3:0]  iss_ra2,
    output logic [3:0]  iss_rwa,
    output logic [3:0]  iss_func,
    output logic [7:0]  iss_ma,
    output logic        err_illegal,
    output logic        busy,
    output logic [15:0] issue_cnt,
    output logic [15:0] stall_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] rwa;
        logic [3:0] func;
        logic [7:0] ma;
    } instr_t;

    instr_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    instr_t        iss_q, iss_d;
    logic          iss_valid_q, iss_valid_d;
    logic          s1_valid_q, s1_valid_d;
    logic [3:0]    s1_rwa_q, s1_rwa_d;
    logic          err_q, err_d;
    logic [15:0]   issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;

    instr_t head, in_instr;
    logic   push, pop, not_empty, head_illegal;
    logic   use_ra1, use_ra2, busy_ra1, busy_ra2, hazard;

    assign in_instr     = '{ra1: in_ra1, ra2: in_ra2, rwa: in_rwa, func: in_func, ma: in_ma};
    assign in_ready     = (count_q < FULL) && !flush;
    assign push         = in_valid && in_ready;
    assign head         = mem_q[rd_ptr_q];
    assign not_empty    = (count_q != '0);
    assign head_illegal = (head.func > 4'd12);

    // Operand usage masks and the scoreboard match against slots S0 (presented) and S1.
    assign use_ra1  = !(head.func == 4'b0100 || head.func == 4'b1010);
    assign use_ra2  = !(head.func == 4'b0011 || head.func == 4'b1001 ||
                        head.func == 4'b1011 || head.func == 4'b1100);
    assign busy_ra1 = (iss_valid_q && iss_q.rwa == head.ra1) || (s1_valid_q && s1_rwa_q == head.ra1);
    assign busy_ra2 = (iss_valid_q && iss_q.rwa == head.ra2) || (s1_valid_q && s1_rwa_q == head.ra2);
    assign hazard   = (use_ra1 && busy_ra1) || (use_ra2 && busy_ra2);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        iss_d       = iss_q;
        iss_valid_d = 1'b0;
        s1_valid_d  = iss_valid_q;
        s1_rwa_d    = iss_q.rwa;
        err_d       = 1'b0;
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        pop         = 1'b0;

        if (!flush && not_empty) begin
            if (head_illegal) begin
                pop   = 1'b1;
                err_d = 1'b1;
            end else if (!hold) begin
                if (hazard) begin
                    if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
                end else begin
                    pop         = 1'b1;
                    iss_valid_d = 1'b1;
                    iss_d       = head;
                    if (issue_cnt_q != 16'hFFFF) issue_cnt_d = issue_cnt_q + 16'd1;
                end
            end
        end

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            iss_q       <= '0;
            iss_valid_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_rwa_q    <= '0;
            err_q       <= 1'b0;
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            iss_q       <= iss_d;
            iss_valid_q <= iss_valid_d;
            s1_valid_q  <= s1_valid_d;
            s1_rwa_q    <= s1_rwa_d;
            err_q       <= err_d;
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // NOTE: queue storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_instr;
    end

    assign iss_valid   = iss_valid_q;
    assign iss_ra1     = iss_q.ra1;
    assign iss_ra2     = iss_q.ra2;
    assign iss_rwa     = iss_q.rwa;
    assign iss_func    = iss_q.func;
    assign iss_ma      = iss_q.ma;
    assign err_illegal = err_q;
    assign busy        = not_empty || iss_valid_q || s1_valid_q;
    assign issue_cnt   = issue_cnt_q;
    assign stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Self-checking bench for pipeline_issue_ctrl: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_pipeline_issue_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, in_valid, hold, flush;
    logic [3:0]  in_ra1, in_ra2, in_rwa, in_func;
    logic [7:0]  in_ma;
    logic        in_ready, iss_valid, err_illegal, busy;
    logic [3:0]  iss_ra1, iss_ra2, iss_rwa, iss_func;
    logic [7:0]  iss_ma;
    logic [15:0] issue_cnt, stall_cnt;

    pipeline_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_ra1(in_ra1), .in_ra2(in_ra2), .in_rwa(in_rwa), .in_func(in_func), .in_ma(in_ma),
        .in_ready(in_ready), .hold(hold), .flush(flush),
        .iss_valid(iss_valid), .iss_ra1(iss_ra1), .iss_ra2(iss_ra2), .iss_rwa(iss_rwa),
        .iss_func(iss_func), .iss_ma(iss_ma), .err_illegal(err_illegal), .busy(busy),
        .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] rwa;
        logic [3:0] func;
        logic [7:0] ma;
    } ins_t;

    // Reference model: a plain queue, plus the cycle in which each register last
    // appeared as an issued destination.
    ins_t mq[$];
    ins_t m_iss;
    bit   m_valid, m_err;
    int   m_issue, m_stall;
    int   cyc;
    int   last_wr[16];
    int   last_issue_cyc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit reads_ra1(input logic [3:0] f);
        return !(f == 4'd4 || f == 4'd10);
    endfunction

    function automatic bit reads_ra2(input logic [3:0] f);
        return !(f == 4'd3 || f == 4'd9 || f == 4'd11 || f == 4'd12);
    endfunction

    // A register written by an instruction presented this cycle or the previous one.
    function automatic bit recent(input logic [3:0] r);
        return (cyc - last_wr[r]) <= 1;
    endfunction

    task automatic model_step();
        ins_t h;
        ins_t n;
        bit   push;
        if (rst) begin
            mq.delete();
            m_iss   = '0;
            m_valid = 0;
            m_err   = 0;
            m_issue = 0;
            m_stall = 0;
            foreach (last_wr[i]) last_wr[i] = -100;
            last_issue_cyc = -100;
        end else begin
            push    = in_valid && (mq.size() < DEPTH) && !flush;
            m_valid = 0;
            m_err   = 0;
            if (flush) begin
                mq.delete();
            end else if (mq.size() > 0) begin
                h = mq[0];
                if (h.func > 4'd12) begin
                    h     = mq.pop_front();
                    m_err = 1;
                end else if (!hold) begin
                    if ((reads_ra1(h.func) && recent(h.ra1)) || (reads_ra2(h.func) && recent(h.ra2))) begin
                        if (m_stall < 65535) m_stall++;
                    end else begin
                        h       = mq.pop_front();
                        m_iss   = h;
                        m_valid = 1;
                        if (m_issue < 65535) m_issue++;
                        last_wr[h.rwa] = cyc + 1;
                        last_issue_cyc = cyc + 1;
                    end
                end
            end
            if (push) begin
                n.ra1 = in_ra1; n.ra2 = in_ra2; n.rwa = in_rwa; n.func = in_func; n.ma = in_ma;
                mq.push_back(n);
            end
        end
        cyc++;
    endtask

    // Inputs are already set by the caller; check the combinational ready, clock, then
    // compare registered outputs on the falling edge.
    task automatic cycle();
        #1;
        check("in_ready", 32'(in_ready), 32'((mq.size() < DEPTH) && !flush));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("iss_valid",   32'(iss_valid),   32'(m_valid));
        check("iss_fields",  32'({iss_ra1, iss_ra2, iss_rwa, iss_func, iss_ma}), 32'(m_iss));
        check("err_illegal", 32'(err_illegal), 32'(m_err));
        check("busy",        32'(busy),        32'((mq.size() > 0) || (cyc - last_issue_cyc <= 1)));
        check("issue_cnt",   32'(issue_cnt),   32'(m_issue));
        check("stall_cnt",   32'(stall_cnt),   32'(m_stall));
    endtask

    task automatic set_in(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] wa,
                          input logic [3:0] f);
        in_valid = 1'b1;
        in_ra1 = a1; in_ra2 = a2; in_rwa = wa; in_func = f;
        in_ma = 8'($urandom);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Reset with a pending enqueue, which must be dropped.
    task automatic do_reset();
        hold = 1'b0; flush = 1'b0; rst = 1'b1;
        set_in(4'd1, 4'd1, 4'd1, 4'd0);
        cycle();
        rst = 1'b0;
        idle();
    endtask

    initial begin
        cyc = 0;
        rst = 1'b1; in_valid = 1'b0; hold = 1'b0; flush = 1'b0;
        in_ra1 = '0; in_ra2 = '0; in_rwa = '0; in_func = '0; in_ma = '0;
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst = 1'b0;

        // Independent stream issues back to back.
        do_reset();
        set_in(4'd1, 4'd2, 4'd3, 4'b0000); cycle();
        set_in(4'd4, 4'd5, 4'd6, 4'b0001); cycle();
        set_in(4'd7, 4'd8, 4'd9, 4'b0010); cycle();
        idle();
        repeat (4) cycle();
        check("t_indep_issue", 32'(issue_cnt), 32'd3);
        check("t_indep_stall", 32'(stall_cnt), 32'd0);

        // RAW dependence costs two stall cycles.
        do_reset();
        set_in(4'd1, 4'd2, 4'd3, 4'b0000); cycle();
        set_in(4'd3, 4'd4, 4'd5, 4'b0000); cycle();
        idle();
        repeat (5) cycle();
        check("t_raw_issue", 32'(issue_cnt), 32'd2);
        check("t_raw_stall", 32'(stall_cnt), 32'd2);

        // Unused operand does not stall; used ra2 does.
        do_reset();
        set_in(4'd1, 4'd2, 4'd3, 4'b0000); cycle();
        set_in(4'd0, 4'd3, 4'd7, 4'b1001); cycle();
        idle();
        repeat (4) cycle();
        check("t_mask_nostall", 32'(stall_cnt), 32'd0);
        do_reset();
        set_in(4'd1, 4'd2, 4'd3, 4'b0000); cycle();
        set_in(4'd0, 4'd3, 4'd7, 4'b0100); cycle();
        idle();
        repeat (5) cycle();
        check("t_mask_stall", 32'(stall_cnt), 32'd2);

        // Self-dependence is not a hazard.
        do_reset();
        set_in(4'd5, 4'd5, 4'd5, 4'b0000); cycle();
        idle();
        repeat (3) cycle();
        check("t_self_stall", 32'(stall_cnt), 32'd0);

        // Fill under hold, then drain in order.
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            set_in(4'(i), 4'(i + 4), 4'(i + 8), 4'b0000);
            cycle();
        end
        set_in(4'd15, 4'd15, 4'd15, 4'b0000);
        #1;
        check("t_full_ready", 32'(in_ready), 32'd0);
        cycle();
        idle();
        hold = 1'b0;
        repeat (8) cycle();
        check("t_full_issue", 32'(issue_cnt), 32'(DEPTH));

        // Illegal head is dropped even while held.
        do_reset();
        hold = 1'b1;
        set_in(4'd1, 4'd2, 4'd3, 4'b1110); cycle();
        set_in(4'd1, 4'd2, 4'd3, 4'b0000); cycle();
        check("t_illegal_err", 32'(err_illegal), 32'd1);
        set_in(4'd4, 4'd5, 4'd6, 4'b0001); cycle();
        set_in(4'd7, 4'd8, 4'd10, 4'b0010); cycle();
        idle();
        cycle();
        check("t_illegal_errclr", 32'(err_illegal), 32'd0);
        hold = 1'b0;
        repeat (6) cycle();
        check("t_illegal_issue", 32'(issue_cnt), 32'd3);

        // Flush refuses the same-cycle push and empties the queue.
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(4'(i), 4'(i), 4'(i), 4'b0000);
            cycle();
        end
        flush = 1'b1;
        set_in(4'd9, 4'd9, 4'd9, 4'b0000);
        #1;
        check("t_flush_ready", 32'(in_ready), 32'd0);
        cycle();
        flush = 1'b0;
        hold  = 1'b0;
        idle();
        check("t_flush_busy", 32'(busy), 32'd0);
        repeat (3) cycle();
        check("t_flush_issue", 32'(issue_cnt), 32'd0);

        // Reset in the middle of a hazard stall.
        set_in(4'd1, 4'd2, 4'd3, 4'b0000); cycle();
        set_in(4'd3, 4'd4, 4'd5, 4'b0000); cycle();
        idle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t_rst_valid", 32'(iss_valid), 32'd0);
        check("t_rst_busy",  32'(busy), 32'd0);
        check("t_rst_cnts",  32'({issue_cnt, stall_cnt}), 32'd0);
        check("t_rst_field", 32'({iss_ra1, iss_ra2, iss_rwa, iss_func, iss_ma}), 32'd0);
        #1;
        check("t_rst_ready", 32'(in_ready), 32'd1);

        // Random traffic with a small register range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(199) == 0);
            flush    = ($urandom_range(39) == 0);
            hold     = ($urandom_range(4) == 0);
            in_valid = ($urandom_range(9) < 6);
            in_ra1   = 4'($urandom_range(3));
            in_ra2   = 4'($urandom_range(3));
            in_rwa   = 4'($urandom_range(3));
            in_func  = 4'($urandom_range(15));
            in_ma    = 8'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_issue_ctrl.md
PIPELINE_ISSUE_CTRL -- requirements
Module: pipeline_issue_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, instruction queue entries (power of two, 2..16).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  instruction offered.
REQ-005 in_ra1, in_ra2, in_rwa, in_func  input  4 each  register read addresses, register write address, ALU operation.
REQ-006 in_ma  input  8  memory write address.
REQ-007 in_ready  output  1  queue accepts the instruction this cycle.
REQ-008 hold  input  1  downstream freeze; no issue while high.
REQ-009 flush  input  1  discard all queued, un-issued instructions.
REQ-010 iss_valid  output  1  registered; datapath instruction fields valid this cycle.
REQ-011 iss_ra1, iss_ra2, iss_rwa, iss_func (4 each), iss_ma (8)  output  registered issued fields.
REQ-012 err_illegal  output  1  one-cycle pulse when an illegal instruction is dropped.
REQ-013 busy  output  1  queue non-empty or any scoreboard slot valid.
REQ-014 issue_cnt, stall_cnt  output  16 each  issued instructions; hazard-stall cycles.

Function
REQ-015 Enqueue occurs when in_valid && in_ready; in_ready = (count < DEPTH) && !flush, combinational from registered state.
REQ-016 Queue is FIFO; fields stored verbatim; pointers wrap modulo DEPTH.
REQ-017 Legal func codes are 4'b0000..4'b1100; 4'b1101..4'b1111 are illegal.
REQ-018 Operand use: func 0011, 1001, 1011, 1100 read ra1 only; 0100, 1010 read ra2 only; all other legal codes read both.
REQ-019 Scoreboard: slot S0 = {iss_valid, iss_rwa} currently presented; slot S1 = S0 of previous cycle; S1 <= S0 every cycle, including bubbles and hold.
REQ-020 Hazard: head reads register R (per REQ-018) and (S0.valid && S0.rwa == R) or (S1.valid && S1.rwa == R).
REQ-021 Each rising edge, priority order: flush > illegal head > hold > hazard > issue.
REQ-022 Illegal head (queue non-empty, not flush): pop without issue, err_illegal = 1 next cycle, iss_valid = 0; applies even while hold or hazard.
REQ-023 Issue: head legal, !hold, no hazard: pop, iss_* <= head fields, iss_valid <= 1; issue_cnt increments.
REQ-024 Otherwise iss_valid <= 0; iss_* fields hold previous values.
REQ-025 stall_cnt increments on each edge where head is legal, !hold, !flush and hazard is true.
REQ-026 Both counters saturate at 16'hFFFF.
REQ-027 Latency: empty queue, no hazard: instruction accepted at edge N appears on iss_* after edge N+1.
REQ-028 Dependent instruction (reads producer's rwa) issues no earlier than 3 cycles after producer's iss_valid cycle.
REQ-029 Push and pop in the same edge both take effect; count unchanged.
REQ-030 Flush: count <= 0, pointers <= 0, iss_valid <= 0; same-cycle push is refused (in_ready low); scoreboard keeps shifting; in-flight instructions unaffected.
REQ-031 Self-dependence (ra1 == rwa in one instruction) is not a hazard.

Reset
REQ-032 On rst at rising edge: queue empty, pointers 0, iss_valid 0, iss_* fields 0, S0/S1 invalid, err_illegal 0, counters 0; in_ready = 1 after the edge.
REQ-033 rst overrides flush, hold and in_valid; an in-progress enqueue at the reset edge is dropped.

Verification
REQ-034 Independent stream: push {ra1=1,ra2=2,rwa=3,f=0000}, {4,5,6,0001}, {7,8,9,0010} on consecutive cycles -> iss_valid high 3 consecutive cycles starting 1 cycle after first push; issue_cnt = 3, stall_cnt = 0.
REQ-035 RAW: push {1,2,rwa=3,f=0000} then {ra1=3,ra2=4,rwa=5,f=0000} -> second iss_valid 3 cycles after first; stall_cnt = 2; two bubble cycles.
REQ-036 Operand masking: producer rwa=3, then {ra1=0,ra2=3,f=1001} -> no stall, back-to-back issue; repeated with f=0100 -> stall_cnt = 2.
REQ-037 Illegal/full: fill DEPTH=4 with hold=1 -> in_ready = 0 at count 4; head func=1110 -> err_illegal pulse despite hold, count = 3; release hold -> remaining 3 issue in order.
REQ-038 Flush and reset: 3 queued, assert flush with in_valid=1 -> count 0, pushed instruction lost, iss_valid 0 next cycle; rst mid-stall -> all outputs per REQ-032, counters 0.
